// File: rtl/iobus_initiator.sv
// MMIO bus initiator: queues read/write commands in a small FIFO and replays
// them one at a time onto a single-cycle IO bus, returning read data via a handshake.
module iobus_initiator #(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_wr,
    input  logic [31:0] i_cmd_addr,
    input  logic [31:0] i_cmd_data,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic [31:0] o_iobus_addr,
    output logic [31:0] o_iobus_out,
    output logic        o_iobus_wr,
    input  logic [31:0] i_iobus_in,
    output logic        o_busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t        r_state;
    logic          r_fifoWr   [DEPTH];
    logic [31:0]   r_fifoAddr [DEPTH];
    logic [31:0]   r_fifoData [DEPTH];
    logic [PW-1:0] r_headPtr;
    logic [PW-1:0] r_tailPtr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Ready depends only on the registered count, so a same-cycle pop never frees a full FIFO.
    assign o_cmd_ready = (r_count < FULL_COUNT);
    assign w_push      = i_cmd_valid && o_cmd_ready;
    assign w_pop       = (r_state == IDLE) && (r_count != '0);
    assign o_busy      = (r_count != '0) || (r_state != IDLE);

    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) begin
            r_fifoWr[r_tailPtr]   <= i_cmd_wr;
            r_fifoAddr[r_tailPtr] <= i_cmd_addr;
            r_fifoData[r_tailPtr] <= i_cmd_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_headPtr <= '0;
            r_tailPtr <= '0;
            r_count   <= '0;
        end else begin
            if (w_push) begin
                r_tailPtr <= r_tailPtr + 1'b1;
            end
            if (w_pop) begin
                r_headPtr <= r_headPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The bus registers double as the in-flight command: o_iobus_wr tells ISSUE whether to capture read data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            o_iobus_addr <= '0;
            o_iobus_out  <= '0;
            o_iobus_wr   <= 1'b0;
            o_rsp_valid  <= 1'b0;
            o_rsp_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        o_iobus_addr <= r_fifoAddr[r_headPtr];
                        o_iobus_out  <= r_fifoData[r_headPtr];
                        o_iobus_wr   <= r_fifoWr[r_headPtr];
                        r_state      <= ISSUE;
                    end else begin
                        o_iobus_addr <= '0;
                        o_iobus_out  <= '0;
                        o_iobus_wr   <= 1'b0;
                    end
                end
                ISSUE: begin
                    o_iobus_addr <= '0;
                    o_iobus_out  <= '0;
                    o_iobus_wr   <= 1'b0;
                    if (o_iobus_wr) begin
                        r_state <= IDLE;
                    end else begin
                        o_rsp_data  <= i_iobus_in;
                        o_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    o_iobus_addr <= '0;
                    o_iobus_out  <= '0;
                    o_iobus_wr   <= 1'b0;
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
